// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared definitions for the memory-port arbiter slice.
//               Default address/data widths, the access-sequencer state
//               encoding and the requester identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 36;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // Requester ids double as bit positions in the 2-bit req/gnt vectors.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. Grant is combinational from the
//               request vector; the priority pointer only moves when the
//               caller signals that a grant was taken (advance_i).
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               req_i[1:0]        - requests (bit 0 = fetch, bit 1 = ld/st)
//               advance_i         - grant is being consumed this cycle
//               gnt_o[1:0]        - one-hot grant (or zero)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import proc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  // Records which requester won most recently; on contention the other one
  // wins. Reset value "ld/st won last" therefore gives fetch first priority.
  logic last_ls_q;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b01) begin
      gnt_o = 2'b01;
    end else if (req_i == 2'b10) begin
      gnt_o = 2'b10;
    end else if (req_i == 2'b11) begin
      gnt_o = last_ls_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ls_q <= 1'b1;
    end else if (advance_i && (gnt_o != 2'b00)) begin
      last_ls_q <= gnt_o[REQ_LS];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between the instruction fetch
//               path and the load/store path. Round-robin arbitration,
//               fixed-latency access sequencing (IDLE -> ISSUE -> WAIT) and
//               per-requester read-data return registers.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               if_req_i/if_addr_i            - fetch request
//               if_gnt_o/if_rvalid_o/if_rdata_o - fetch grant and return data
//               ls_req_i/ls_we_i/ls_addr_i/ls_wdata_i - load/store request
//               ls_gnt_o/ls_rvalid_o/ls_rdata_o - load/store grant and data
//               mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i - memory
//               busy_o                        - sequencer not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int CNT_W = 3;

  if ((MEM_LAT < 1) || (MEM_LAT > 7)) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must lie in 1..7");
  end

  state_e              state_q;
  logic                id_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                if_rvalid_q;
  logic                ls_rvalid_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   ls_rdata_q;

  logic [1:0]          w_arb_gnt;
  logic                w_idle;
  logic                w_gnt_if;
  logic                w_gnt_ls;

  assign w_idle = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     ({ls_req_i, if_req_i}),
    .advance_i (w_idle),
    .gnt_o     (w_arb_gnt)
  );

  // Grants are combinational; gating with rst_n keeps them low while reset
  // is asserted even if a requester is holding its request.
  assign w_gnt_if = rst_n & w_idle & w_arb_gnt[REQ_IF];
  assign w_gnt_ls = rst_n & w_idle & w_arb_gnt[REQ_LS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      id_q        <= REQ_IF;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // The winner's access is captured straight into the memory-side
          // registers so that mem_* are registered outputs in ISSUE.
          if (w_gnt_if || w_gnt_ls) begin
            id_q        <= w_gnt_ls ? REQ_LS : REQ_IF;
            mem_addr_q  <= w_gnt_ls ? ls_addr_i : if_addr_i;
            mem_we_q    <= w_gnt_ls & ls_we_i;
            mem_wdata_q <= w_gnt_ls ? ls_wdata_i : '0;
            mem_en_q    <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          cnt_q    <= CNT_W'(MEM_LAT);
          state_q  <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            if (id_q == REQ_IF) begin
              if_rdata_q  <= mem_rdata_i;
              if_rvalid_q <= 1'b1;
            end else begin
              // Stores complete with a pulse but leave ls_rdata untouched.
              if (!mem_we_q_store(id_q)) begin
                ls_rdata_q <= mem_rdata_i;
              end
              ls_rvalid_q <= 1'b1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The write flag is cleared after ISSUE, so the store/load distinction for
  // the completing access is kept separately.
  logic store_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= 1'b0;
    end else if (w_gnt_if || w_gnt_ls) begin
      store_q <= w_gnt_ls & ls_we_i;
    end
  end

  function automatic logic mem_we_q_store(input logic id);
    return (id == REQ_LS) && store_q;
  endfunction

  assign if_gnt_o    = w_gnt_if;
  assign ls_gnt_o    = w_gnt_ls;
  assign if_rvalid_o = if_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A cycle table covers
//               the directed scenarios, hand sequences cover reset and
//               contention, and a randomized phase is compared against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 36;
  localparam int LAT = 2;
  localparam int NRAND = 600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (MEM_LAT = 2) ----------------
  logic          if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [AW-1:0] if_addr = '0, ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  // ---------------- DUT B (MEM_LAT = 1), fetch only ----------------
  logic          b_if_req = 1'b0, b_ls_req = 1'b0, b_ls_we = 1'b0;
  logic [AW-1:0] b_if_addr = '0, b_ls_addr = '0;
  logic [DW-1:0] b_ls_wdata = '0;
  logic          b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_en, b_mem_we, b_busy;
  logic [DW-1:0] b_if_rdata, b_ls_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0] b_mem_addr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_gnt_o(b_if_gnt),
    .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
    .ls_req_i(b_ls_req), .ls_we_i(b_ls_we), .ls_addr_i(b_ls_addr), .ls_wdata_i(b_ls_wdata),
    .ls_gnt_o(b_ls_gnt), .ls_rvalid_o(b_ls_rvalid), .ls_rdata_o(b_ls_rdata),
    .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata), .busy_o(b_busy)
  );

  // ---------------- memory models ----------------
  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {a, ~a, a, 12'h5A5};
  endfunction

  // Data outside the exact return cycle is random so that sampling in the
  // wrong cycle shows up as wrong data.
  function automatic logic [DW-1:0] junk();
    return {4'($urandom_range(0, 15)), 32'($urandom())};
  endfunction

  logic [DW-1:0] memA [256];
  logic [DW-1:0] pipeA [8];
  logic [DW-1:0] pipeB [8];
  assign mem_rdata   = pipeA[LAT-1];
  assign b_mem_rdata = pipeB[0];

  always @(posedge clk) begin
    for (int k = 7; k > 0; k--) begin
      pipeA[k] <= pipeA[k-1];
      pipeB[k] <= pipeB[k-1];
    end
    pipeA[0] <= (mem_en && !mem_we) ? memA[mem_addr] : junk();
    if (mem_en && mem_we) memA[mem_addr] <= mem_wdata;
    pipeB[0] <= b_mem_en ? memf(b_mem_addr) : junk();
  end

  // ---------------- checking ----------------
  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic ifr; logic [AW-1:0] ifa; logic lsr; logic lswe; logic [AW-1:0] lsa; logic [DW-1:0] lswd;
    logic eig; logic elg; logic een; logic ewe; logic [AW-1:0] eaddr; logic [DW-1:0] ewd;
    logic ebusy; logic eirv; logic elrv; logic [DW-1:0] eird; logic [DW-1:0] elrd;
  } vec_t;

  function automatic vec_t mkv(
      input logic ifr, input logic [AW-1:0] ifa, input logic lsr, input logic lswe,
      input logic [AW-1:0] lsa, input logic [DW-1:0] lswd,
      input logic eig, input logic elg, input logic een, input logic ewe,
      input logic [AW-1:0] eaddr, input logic [DW-1:0] ewd,
      input logic ebusy, input logic eirv, input logic elrv,
      input logic [DW-1:0] eird, input logic [DW-1:0] elrd);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.lsr = lsr; v.lswe = lswe; v.lsa = lsa; v.lswd = lswd;
    v.eig = eig; v.elg = elg; v.een = een; v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd;
    v.ebusy = ebusy; v.eirv = eirv; v.elrv = elrv; v.eird = eird; v.elrd = elrd;
    return v;
  endfunction

  vec_t tbl[$];
  logic [DW-1:0] d10, d11, d30, d40, d41;
  localparam logic [DW-1:0] Z = '0;

  // reference-model state
  logic [DW-1:0] mref [256];
  int   g, nf;
  logic last_ls, m_ls, m_we, win_ls, e_ig, e_lg, e_en, e_busy, e_irv, e_lrv;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_data, e_ird, e_lrd;
  int   gcyc[$];
  logic gid[$];

  initial begin
    for (int i = 0; i < 256; i++) memA[i] = memf(AW'(i));
    memA[8'h10] = 36'h000000123;
    d10 = 36'h000000123; d11 = memf(8'h11); d30 = memf(8'h30);
    d40 = memf(8'h40);   d41 = memf(8'h41);

    // ---- reset state, with both requests held during reset ----
    if_req = 1'b1; ls_req = 1'b1;
    #12;
    chk("rst_if_gnt", if_gnt, 0);     chk("rst_ls_gnt", ls_gnt, 0);
    chk("rst_mem_en", mem_en, 0);     chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);         chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rvalid", if_rvalid, 0); chk("rst_ls_rvalid", ls_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0); chk("rst_ls_rdata", ls_rdata, 0);
    tick();
    rst_n = 1'b1; if_req = 1'b0; ls_req = 1'b0;

    // ---- directed cycle table ----
    // single fetch
    tbl.push_back(mkv(1,8'h10,0,0,0,Z, 1,0,0,0,0,Z, 0,0,0,Z,Z));
    tbl.push_back(mkv(0,0,0,0,0,Z, 0,0,1,0,8'h10,Z, 1,0,0,Z,Z));
    tbl.push_back(mkv(0,0,0,0,0,Z, 0,0,0,0,0,Z, 1,0,0,Z,Z));
    tbl.push_back(mkv(0,0,0,0,0,Z, 0,0,0,0,0,Z, 1,0,0,Z,Z));
    tbl.push_back(mkv(0,0,0,0,0,Z, 0,0,0,0,0,Z, 0,1,0,d10,Z));
    // store
    tbl.push_back(mkv(0,0,1,1,8'h20,36'hABC, 0,1,0,0,0,Z, 0,0,0,d10,Z));
    tbl.push_back(mkv(0,0,0,0,0,Z, 0,0,1,1,8'h20,36'hABC, 1,0,0,d10,Z));
    tbl.push_back(mkv(0,0,0,0,0,Z, 0,0,0,0,0,Z, 1,0,0,d10,Z));
    tbl.push_back(mkv(0,0,0,0,0,Z, 0,0,0,0,0,Z, 1,0,0,d10,Z));
    tbl.push_back(mkv(0,0,0,0,0,Z, 0,0,0,0,0,Z, 0,0,1,d10,Z));
    // load request raised while a fetch is in flight
    tbl.push_back(mkv(1,8'h11,0,0,0,Z, 1,0,0,0,0,Z, 0,0,0,d10,Z));
    tbl.push_back(mkv(0,0,0,0,0,Z, 0,0,1,0,8'h11,Z, 1,0,0,d10,Z));
    tbl.push_back(mkv(0,0,1,0,8'h30,Z, 0,0,0,0,0,Z, 1,0,0,d10,Z));
    tbl.push_back(mkv(0,0,1,0,8'h30,Z, 0,0,0,0,0,Z, 1,0,0,d10,Z));
    tbl.push_back(mkv(0,0,1,0,8'h30,Z, 0,1,0,0,0,Z, 0,1,0,d11,Z));
    tbl.push_back(mkv(0,0,0,0,0,Z, 0,0,1,0,8'h30,Z, 1,0,0,d11,Z));
    tbl.push_back(mkv(0,0,0,0,0,Z, 0,0,0,0,0,Z, 1,0,0,d11,Z));
    tbl.push_back(mkv(0,0,0,0,0,Z, 0,0,0,0,0,Z, 1,0,0,d11,Z));
    tbl.push_back(mkv(0,0,0,0,0,Z, 0,0,0,0,0,Z, 0,0,1,d11,d30));
    // contention after an ld/st win: fetch first, then alternate
    tbl.push_back(mkv(1,8'h40,1,0,8'h41,Z, 1,0,0,0,0,Z, 0,0,0,d11,d30));
    tbl.push_back(mkv(1,8'h40,1,0,8'h41,Z, 0,0,1,0,8'h40,Z, 1,0,0,d11,d30));
    tbl.push_back(mkv(1,8'h40,1,0,8'h41,Z, 0,0,0,0,0,Z, 1,0,0,d11,d30));
    tbl.push_back(mkv(1,8'h40,1,0,8'h41,Z, 0,0,0,0,0,Z, 1,0,0,d11,d30));
    tbl.push_back(mkv(1,8'h40,1,0,8'h41,Z, 0,1,0,0,0,Z, 0,1,0,d40,d30));
    tbl.push_back(mkv(1,8'h40,1,0,8'h41,Z, 0,0,1,0,8'h41,Z, 1,0,0,d40,d30));
    tbl.push_back(mkv(1,8'h40,1,0,8'h41,Z, 0,0,0,0,0,Z, 1,0,0,d40,d30));
    tbl.push_back(mkv(1,8'h40,1,0,8'h41,Z, 0,0,0,0,0,Z, 1,0,0,d40,d30));
    tbl.push_back(mkv(1,8'h40,1,0,8'h41,Z, 1,0,0,0,0,Z, 0,0,1,d40,d41));
    tbl.push_back(mkv(1,8'h40,1,0,8'h41,Z, 0,0,1,0,8'h40,Z, 1,0,0,d40,d41));
    tbl.push_back(mkv(1,8'h40,1,0,8'h41,Z, 0,0,0,0,0,Z, 1,0,0,d40,d41));
    tbl.push_back(mkv(1,8'h40,1,0,8'h41,Z, 0,0,0,0,0,Z, 1,0,0,d40,d41));
    tbl.push_back(mkv(1,8'h40,1,0,8'h41,Z, 0,1,0,0,0,Z, 0,1,0,d40,d41));

    for (int i = 0; i < tbl.size(); i++) begin
      tick();
      if_req = tbl[i].ifr; if_addr = tbl[i].ifa;
      ls_req = tbl[i].lsr; ls_we = tbl[i].lswe; ls_addr = tbl[i].lsa; ls_wdata = tbl[i].lswd;
      #3;
      chk($sformatf("tbl%0d_if_gnt", i), if_gnt, tbl[i].eig);
      chk($sformatf("tbl%0d_ls_gnt", i), ls_gnt, tbl[i].elg);
      chk($sformatf("tbl%0d_mem_en", i), mem_en, tbl[i].een);
      chk($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].ewe);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
      chk($sformatf("tbl%0d_if_rvalid", i), if_rvalid, tbl[i].eirv);
      chk($sformatf("tbl%0d_ls_rvalid", i), ls_rvalid, tbl[i].elrv);
      chk($sformatf("tbl%0d_if_rdata", i), if_rdata, tbl[i].eird);
      chk($sformatf("tbl%0d_ls_rdata", i), ls_rdata, tbl[i].elrd);
      if (tbl[i].een) chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].eaddr);
      if (tbl[i].ewe) chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata, tbl[i].ewd);
    end

    // drain the access granted in the last row
    if_req = 1'b0; ls_req = 1'b0;
    begin
      int k;
      k = 0;
      do begin tick(); k++; end while (busy && k < 20);
      chk("drain_busy", busy, 0);
    end

    // ---- reset in the middle of a fetch ----
    tick(); if_req = 1'b1; if_addr = 8'h12; #3;
    chk("rma_gnt", if_gnt, 1);
    tick(); if_req = 1'b0; #3;
    chk("rma_issue_en", mem_en, 1);
    tick(); #3;
    chk("rma_wait_busy", busy, 1);
    rst_n = 1'b0; #1;
    chk("rma_mem_en", mem_en, 0);     chk("rma_busy", busy, 0);
    chk("rma_if_rvalid", if_rvalid, 0); chk("rma_if_rdata", if_rdata, 0);
    for (int k = 0; k < 3; k++) begin
      tick(); #3;
      chk("rma_in_reset_rvalid", if_rvalid, 0);
    end
    tick(); rst_n = 1'b1; if_req = 1'b1; if_addr = 8'h13; #3;
    chk("rma_first_gnt", if_gnt, 1);
    for (int k = 1; k <= 4; k++) begin
      tick(); if_req = 1'b0; #3;
      chk($sformatf("rma_rvalid_c%0d", k), if_rvalid, (k == 4));
      if (k == 4) chk("rma_rdata", if_rdata, memf(8'h13));
    end

    // ---- randomized traffic against the transaction-level model ----
    rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    tick(); tick();
    for (int i = 0; i < 256; i++) mref[i] = memA[i];
    g = -100; nf = 0; last_ls = 1'b1; e_ird = '0; e_lrd = '0;
    e_ig = 1'b0; e_lg = 1'b0; m_ls = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0; m_data = '0;
    rst_n = 1'b1;
    for (int t = 0; t < NRAND; t++) begin
      if (t > 0) tick();
      // requesters: hold until granted, occasionally withdraw
      if (e_ig) begin
        if_req = ($urandom_range(0, 1) == 0);
        if_addr = AW'($urandom_range(0, 15));
      end else if (if_req) begin
        if ($urandom_range(0, 15) == 0) if_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = AW'($urandom_range(0, 15));
      end
      if (e_lg || (!ls_req && $urandom_range(0, 2) == 0)) begin
        ls_req = e_lg ? ($urandom_range(0, 1) == 0) : 1'b1;
        ls_we = $urandom_range(0, 1) == 1;
        ls_addr = AW'($urandom_range(0, 15));
        ls_wdata = junk();
      end else if (ls_req && $urandom_range(0, 15) == 0) begin
        ls_req = 1'b0;
      end
      #3;
      // outputs owed by the access in flight
      e_en   = (t == g + 1);
      e_busy = (t >= g + 1) && (t <= g + 1 + LAT);
      e_irv  = 1'b0; e_lrv = 1'b0;
      if (t == g + 2 + LAT) begin
        if (!m_ls) begin e_irv = 1'b1; e_ird = m_data; end
        else begin e_lrv = 1'b1; if (!m_we) e_lrd = m_data; end
      end
      // new grant once the port is free
      e_ig = 1'b0; e_lg = 1'b0;
      if (t >= nf && (if_req || ls_req)) begin
        win_ls = ls_req && (!if_req || !last_ls);
        g = t; nf = t + 2 + LAT; last_ls = win_ls; m_ls = win_ls;
        m_we = win_ls && ls_we;
        m_addr = win_ls ? ls_addr : if_addr;
        m_wd = ls_wdata;
        if (m_we) mref[m_addr] = m_wd;
        else m_data = mref[m_addr];
        e_ig = !win_ls; e_lg = win_ls;
      end
      chk("rnd_if_gnt", if_gnt, e_ig);   chk("rnd_ls_gnt", ls_gnt, e_lg);
      chk("rnd_mem_en", mem_en, e_en);   chk("rnd_mem_we", mem_we, e_en && m_we);
      chk("rnd_busy", busy, e_busy);
      chk("rnd_if_rvalid", if_rvalid, e_irv); chk("rnd_ls_rvalid", ls_rvalid, e_lrv);
      chk("rnd_if_rdata", if_rdata, e_ird);   chk("rnd_ls_rdata", ls_rdata, e_lrd);
      if (e_en) chk("rnd_mem_addr", mem_addr, m_addr);
      if (e_en && m_we) chk("rnd_mem_wdata", mem_wdata, m_wd);
    end

    // ---- contention from reset release ----
    rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 8'h40; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h41;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) tick();
      #3;
      if (if_gnt || ls_gnt) begin gcyc.push_back(k); gid.push_back(ls_gnt); end
    end
    if_req = 1'b0; ls_req = 1'b0;
    chk("cont_grants", gcyc.size(), 4);
    for (int j = 0; j < 4 && j < gcyc.size(); j++) begin
      chk($sformatf("cont_id%0d", j), gid[j], (j % 2));
      chk($sformatf("cont_cyc%0d", j), gcyc[j], 4 * j);
    end

    // ---- back-to-back fetches on the MEM_LAT=1 instance ----
    tick();
    for (int k = 0; k < 15; k++) begin
      if (k > 0) tick();
      b_if_req = 1'b1;
      b_if_addr = AW'(8'h50 + (k + 2) / 3);
      #3;
      chk("b2b_gnt", b_if_gnt, (k % 3 == 0));
      chk("b2b_mem_en", b_mem_en, (k % 3 == 1));
      if (k % 3 == 1) chk("b2b_mem_addr", b_mem_addr, 8'h50 + k / 3);
      chk("b2b_rvalid", b_if_rvalid, (k % 3 == 0) && (k > 0));
      if ((k % 3 == 0) && (k > 0)) chk("b2b_rdata", b_if_rdata, memf(AW'(8'h50 + k / 3 - 1)));
    end
    b_if_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data memory between the instruction-fetch requester (PC path) and the load/store requester (register-addressed path, M4 side) under the control unit.
- Arbitrates between them, sequences the fixed-latency memory access, and returns read data to the winner.
- Replaces the ad-hoc M4 address select with a request/grant handshake.

Parameters:
- ADDR_W, 8: memory address width.
- DATA_W, 36: memory word width. Equals the instruction width.
- MEM_LAT, 2: cycles from the mem_en cycle to valid mem_rdata. Legal range 1..7; any other value is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle grant to fetch
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched word; held until next fetch completion
- ls_req  in  1  load/store request; held until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  one-cycle grant to load/store
- ls_rvalid  out  1  one-cycle completion pulse (loads and stores)
- ls_rdata  out  DATA_W  loaded word; unchanged by stores
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  registered access address
- mem_wdata  out  DATA_W  registered store data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE and the round-robin pointer favours fetch.
  - All outputs go to 0, including if_rdata/ls_rdata and mem_en, immediately.
  - An in-flight access is discarded; no rvalid is produced for it.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: gnt is combinational. If exactly one req is high, that requester is granted. If both are high, the requester not granted last time wins. On grant, the winner's id, addr, we and wdata are registered (a fetch registers we=0) and the next state is ISSUE. With no req, stay in IDLE.
  - ISSUE (one cycle): mem_en=1; mem_we, mem_addr, mem_wdata come from the registered values. A latency counter loads MEM_LAT and the next state is WAIT.
  - WAIT: the counter decrements each cycle.
    - At count 1, mem_rdata is sampled into the winner's rdata register (loads/fetches only) and the state goes to IDLE.
    - The winner's rvalid pulses in the following cycle, the first IDLE cycle.
    - A new grant may be issued in that same cycle.
- Latency: grant in cycle c; mem_en in cycle c+1; rvalid in cycle c+2+MEM_LAT. Peak throughput is one access per MEM_LAT+2 cycles.
- Requests raised while busy are not granted; they must be held and are arbitrated in the next IDLE cycle.
- Dropping req before gnt is legal and produces no grant.
- The round-robin pointer updates only on a grant.
- Single-requester traffic is never delayed by the pointer.
- mem_we is 0 whenever mem_en is 0.
- No data is forwarded between requesters; each rdata register is written only by its own completions.

Decomposition:
- Shared package (proc_pkg):
  - ADDR_W/DATA_W defaults.
  - State encoding for IDLE/ISSUE/WAIT.
  - Requester id constants REQ_IF=0, REQ_LS=1.
- One sub-module: rr_arb2, the 2-way round-robin arbiter (req[1:0], advance, gnt[1:0], pointer register, asynchronous active-low reset).

Test Plan:
- Reset mid-access:
  - Stimulus: rst_n low during WAIT of a fetch.
  - Response: mem_en, busy, if_rvalid, if_rdata = 0 at once; no if_rvalid after release. A subsequent if_req is granted in the first cycle after rst_n rises.
- Single fetch, MEM_LAT=2:
  - Stimulus: if_req, if_addr=0x10 in cycle 0; memory returns 0x000000123.
  - Response: if_gnt in cycle 0; mem_en=1, mem_addr=0x10, mem_we=0 in cycle 1; if_rvalid=1 with if_rdata=0x000000123 in cycle 4.
- Contention:
  - Stimulus: if_req and ls_req both held high from reset release.
  - Response: grant order F, L, F, L; grants 4 cycles apart.
- Store, MEM_LAT=2:
  - Stimulus: ls_req, ls_we=1, ls_addr=0x20, ls_wdata=0xABC.
  - Response: mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0xABC in cycle 1; ls_rvalid in cycle 4; ls_rdata unchanged; if_rvalid stays 0.
- Request while busy:
  - Stimulus: ls_req raised in cycle 2 of a fetch granted in cycle 0.
  - Response: ls_gnt=0 until cycle 4; ls_gnt=1 in cycle 4, coincident with if_rvalid.
- Back-to-back fetches, MEM_LAT=1:
  - Stimulus: if_req held high with incrementing addresses.
  - Response: if_gnt every 3 cycles; mem_en every 3 cycles; each if_rvalid carries the data for its own address.
